// File: rtl/pixel_ray_scheduler.sv
// Raster-order pixel issuer for the ray generator, with credit-limited rays in flight.
// Optional credit-stall cycle counter enabled by defining PIXEL_SCHED_STALL_CNT_EN.
module pixel_ray_scheduler #(
    parameter int H_PIXELS     = 320,
    parameter int V_PIXELS     = 180,
    parameter int MAX_INFLIGHT = 32
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [10:0] hcount_axis_tdata,
    output logic        hcount_axis_tvalid,
    input  logic        hcount_axis_tready,
    output logic [9:0]  vcount_axis_tdata,
    output logic        vcount_axis_tvalid,
    input  logic        vcount_axis_tready,
    input  logic        ray_retire,
    output logic [7:0]  inflight,
    output logic        err_underflow
`ifdef PIXEL_SCHED_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [10:0] X_LAST     = 11'(H_PIXELS - 1);
    localparam logic [9:0]  Y_LAST     = 10'(V_PIXELS - 1);
    localparam logic [7:0]  CREDIT_MAX = 8'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t      state_reg;
    logic [10:0] x_reg;
    logic [9:0]  y_reg;
    logic [7:0]  inflight_reg;
    logic [7:0]  inflight_next;
    logic        acc_h_reg;
    logic        acc_v_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        err_reg;

    logic in_issue;
    logic credit_ok;
    logic valid_h;
    logic valid_v;
    logic got_h;
    logic got_v;
    logic issue;
    logic last_px;

    // tvalid depends only on registered state: inflight can only fall while a
    // channel waits, so an asserted tvalid is never withdrawn before handshake.
    assign in_issue  = (state_reg == S_ISSUE);
    assign credit_ok = (inflight_reg < CREDIT_MAX);
    assign valid_h   = in_issue && !acc_h_reg && credit_ok;
    assign valid_v   = in_issue && !acc_v_reg && credit_ok;
    assign got_h     = acc_h_reg || (valid_h && hcount_axis_tready);
    assign got_v     = acc_v_reg || (valid_v && vcount_axis_tready);
    assign issue     = in_issue && got_h && got_v;
    assign last_px   = (x_reg == X_LAST) && (y_reg == Y_LAST);

    always_comb begin
        inflight_next = inflight_reg;
        if (issue && !ray_retire) begin
            inflight_next = inflight_reg + 8'd1;
        end else if (!issue && ray_retire && inflight_reg != 8'd0) begin
            inflight_next = inflight_reg - 8'd1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg <= S_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            acc_h_reg <= 1'b0;
            acc_v_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg <= S_ISSUE;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        acc_h_reg <= 1'b0;
                        acc_v_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    acc_h_reg <= got_h && !issue;
                    acc_v_reg <= got_v && !issue;
                    if (issue) begin
                        if (x_reg == X_LAST) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 10'd1;
                        end else begin
                            x_reg <= x_reg + 11'd1;
                        end
                        if (last_px) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // No issue can occur here, so inflight_next reflects only retires.
                    if (inflight_next == 8'd0) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            inflight_reg <= inflight_next;
            if (ray_retire && !issue && inflight_reg == 8'd0) begin
                err_reg <= 1'b1;
            end
        end
    end

`ifdef PIXEL_SCHED_STALL_CNT_EN
    logic [31:0] stall_reg;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stall_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            stall_reg <= '0;
        end else if (in_issue && inflight_reg == CREDIT_MAX) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

    assign busy               = busy_reg;
    assign done               = done_reg;
    assign hcount_axis_tdata  = x_reg;
    assign vcount_axis_tdata  = y_reg;
    assign hcount_axis_tvalid = valid_h;
    assign vcount_axis_tvalid = valid_v;
    assign inflight           = inflight_reg;
    assign err_underflow      = err_reg;

endmodule

// File: tb/tb_pixel_ray_scheduler.sv
// Scoreboard bench for pixel_ray_scheduler: 4x3 frame with 2 credits, plus a 1x1 instance.
module tb_pixel_ray_scheduler;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [10:0] hd;
    logic        hv;
    logic        hr = 1'b0;
    logic [9:0]  vd;
    logic        vv;
    logic        vr = 1'b0;
    logic        auto_ret = 1'b0;
    logic        man_ret = 1'b0;
    logic        ray_retire;
    logic [7:0]  inflight;
    logic        err;

    logic        start1 = 1'b0;
    logic        busy1, done1;
    logic [10:0] hd1;
    logic        hv1;
    logic        hr1 = 1'b0;
    logic [9:0]  vd1;
    logic        vv1;
    logic        vr1 = 1'b0;
    logic        ret1 = 1'b0;
    logic [7:0]  inf1;
    logic        err1;
`ifdef PIXEL_SCHED_STALL_CNT_EN
    logic [31:0] stall0, stall1;
`endif

    assign ray_retire = auto_ret | man_ret;

    always #5 clk = ~clk;

    pixel_ray_scheduler #(.H_PIXELS(4), .V_PIXELS(3), .MAX_INFLIGHT(2)) dut (
        .aclk(clk), .areset(areset), .start(start), .busy(busy), .done(done),
        .hcount_axis_tdata(hd), .hcount_axis_tvalid(hv), .hcount_axis_tready(hr),
        .vcount_axis_tdata(vd), .vcount_axis_tvalid(vv), .vcount_axis_tready(vr),
        .ray_retire(ray_retire), .inflight(inflight), .err_underflow(err)
`ifdef PIXEL_SCHED_STALL_CNT_EN
        , .stall_cycles(stall0)
`endif
    );

    pixel_ray_scheduler #(.H_PIXELS(1), .V_PIXELS(1), .MAX_INFLIGHT(2)) dut1 (
        .aclk(clk), .areset(areset), .start(start1), .busy(busy1), .done(done1),
        .hcount_axis_tdata(hd1), .hcount_axis_tvalid(hv1), .hcount_axis_tready(hr1),
        .vcount_axis_tdata(vd1), .vcount_axis_tvalid(vv1), .vcount_axis_tready(vr1),
        .ray_retire(ret1), .inflight(inf1), .err_underflow(err1)
`ifdef PIXEL_SCHED_STALL_CNT_EN
        , .stall_cycles(stall1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int issued = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_ret = 0;
    int max_inf = 0;
    logic auto_mode = 1'b0;

    logic [20:0] exp_q[$];
    logic [10:0] hq[$];
    logic [9:0]  vq[$];
    int          rq[$];
    logic [20:0] exp_px;
    logic [10:0] px_x;
    logic [9:0]  px_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        start = 1'b0; hr = 1'b0; vr = 1'b0; man_ret = 1'b0; auto_mode = 1'b0;
        start1 = 1'b0; hr1 = 1'b0; vr1 = 1'b0; ret1 = 1'b0;
        step(2);
        areset = 1'b0;
        step(1);
    endtask

    task automatic push_frame();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                exp_q.push_back({11'(x), 10'(y)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Retires scheduled three cycles after each observed issue.
    always @(posedge clk) begin
        #1;
        auto_ret = 1'b0;
        if (rq.size() > 0 && rq[0] <= cyc) begin
            auto_ret = 1'b1;
            void'(rq.pop_front());
        end
    end

    // Monitor: pairs channel handshakes into pixels and checks them against the scoreboard.
    always @(negedge clk) begin
        if (areset) begin
            exp_q.delete(); hq.delete(); vq.delete(); rq.delete();
            issued = 0; done_cnt = 0; done_cyc = 0; last_ret = 0; max_inf = 0;
        end else begin
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            if (ray_retire) last_ret = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hv && hr) hq.push_back(hd);
            if (vv && vr) vq.push_back(vd);
            if (hq.size() > 0 && vq.size() > 0) begin
                px_x = hq.pop_front();
                px_y = vq.pop_front();
                issued++;
                $display("pixel %0d: (%0d,%0d) cycle %0d inflight %0d", issued, px_x, px_y, cyc, inflight);
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_px", 32'd1, 32'd0);
                end else begin
                    exp_px = exp_q.pop_front();
                    check("px_x", 32'(px_x), 32'(exp_px[20:10]));
                    check("px_y", 32'(px_y), 32'(exp_px[9:0]));
                end
                if (auto_mode) rq.push_back(cyc + 3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_hvalid", 32'(hv), 0);
        check("rst_vvalid", 32'(vv), 0);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_err", 32'(err), 0);
        check("rst_x", 32'(hd), 0);
        check("rst_y", 32'(vd), 0);
        areset = 1'b0;
        step(1);

        // Full-rate fill and drain
        do_reset();
        hr = 1'b1; vr = 1'b1; auto_mode = 1'b1;
        push_frame();
        pulse_start();
        check("full_busy", 32'(busy), 1);
        for (int i = 0; i < 300 && done_cnt == 0; i++) step(1);
        step(4);
        check("full_issued", 32'(issued), 12);
        check("full_done_cnt", 32'(done_cnt), 1);
        check("full_done_lat", 32'(done_cyc - last_ret), 1);
        check("full_max_inflight", 32'(max_inf), 2);
        check("full_busy_after", 32'(busy), 0);
        check("full_inflight_after", 32'(inflight), 0);
        check("full_sb_left", 32'(exp_q.size()), 0);
        check("full_err", 32'(err), 0);

        // Skewed acceptance
        do_reset();
        hr = 1'b1; vr = 1'b0;
        push_frame();
        pulse_start();
        check("skew_hvalid0", 32'(hv), 1);
        check("skew_vvalid0", 32'(vv), 1);
        step(1);
        check("skew_hvalid1", 32'(hv), 0);
        check("skew_vvalid1", 32'(vv), 1);
        check("skew_y1", 32'(vd), 0);
        step(1);
        check("skew_vvalid2", 32'(vv), 1);
        check("skew_y2", 32'(vd), 0);
        check("skew_issued_wait", 32'(issued), 0);
        vr = 1'b1;
        step(1);
        check("skew_issued", 32'(issued), 1);
        check("skew_inflight", 32'(inflight), 1);
        check("skew_next_x", 32'(hd), 1);
        check("skew_hvalid_next", 32'(hv), 1);

        // Credit stall
        do_reset();
        hr = 1'b1; vr = 1'b1;
        push_frame();
        pulse_start();
        step(8);
        check("stall_issued", 32'(issued), 2);
        check("stall_hvalid", 32'(hv), 0);
        check("stall_vvalid", 32'(vv), 0);
        check("stall_inflight", 32'(inflight), 2);
        check("stall_x", 32'(hd), 2);
        man_ret = 1'b1;
        step(1);
        man_ret = 1'b0;
        check("stall_ret_inflight", 32'(inflight), 1);
        check("stall_ret_hvalid", 32'(hv), 1);
        check("stall_ret_issued", 32'(issued), 2);
        step(1);
        check("stall_third_issued", 32'(issued), 3);
        check("stall_third_inflight", 32'(inflight), 2);

        // Simultaneous issue and retire
        do_reset();
        hr = 1'b1; vr = 1'b0;
        push_frame();
        pulse_start();
        step(2);
        check("sim_pre_inflight", 32'(inflight), 0);
        vr = 1'b1;
        step(1);
        vr = 1'b0;
        check("sim_one_inflight", 32'(inflight), 1);
        step(1);
        vr = 1'b1; man_ret = 1'b1;
        step(1);
        vr = 1'b0; man_ret = 1'b0;
        check("sim_inflight", 32'(inflight), 1);
        check("sim_issued", 32'(issued), 2);
        check("sim_err", 32'(err), 0);

        // Retire in IDLE
        do_reset();
        man_ret = 1'b1;
        step(1);
        man_ret = 1'b0;
        check("uf_err", 32'(err), 1);
        check("uf_inflight", 32'(inflight), 0);
        step(2);
        check("uf_err_sticky", 32'(err), 1);

        // Reset mid-frame at (2,1) with inflight=2
        do_reset();
        hr = 1'b1; vr = 1'b1;
        push_frame();
        pulse_start();
        step(5);
        for (int i = 0; i < 4; i++) begin
            man_ret = 1'b1;
            step(1);
            man_ret = 1'b0;
            step(2);
        end
        check("mid_issued", 32'(issued), 6);
        check("mid_x", 32'(hd), 2);
        check("mid_y", 32'(vd), 1);
        check("mid_inflight", 32'(inflight), 2);
        check("mid_busy", 32'(busy), 1);
        #1;
        areset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_inflight", 32'(inflight), 0);
        check("mid_rst_hvalid", 32'(hv), 0);
        check("mid_rst_vvalid", 32'(vv), 0);
        check("mid_rst_x", 32'(hd), 0);
        check("mid_rst_y", 32'(vd), 0);
        step(1);
        areset = 1'b0;
        step(1);
        push_frame();
        pulse_start();
        step(3);
        check("mid_restart_issued", 32'(issued), 2);

        // 1x1 frame on the second instance
        do_reset();
        hr1 = 1'b1; vr1 = 1'b1;
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        check("one_hvalid", 32'(hv1), 1);
        check("one_vvalid", 32'(vv1), 1);
        check("one_xy", 32'({hd1, vd1}), 0);
        check("one_busy", 32'(busy1), 1);
        step(1);
        check("one_inflight", 32'(inf1), 1);
        check("one_hvalid_drain", 32'(hv1), 0);
        check("one_done_early", 32'(done1), 0);
        ret1 = 1'b1;
        step(1);
        ret1 = 1'b0;
        check("one_done", 32'(done1), 1);
        check("one_busy_done", 32'(busy1), 0);
        start1 = 1'b1;
        step(1);
        start1 = 1'b0;
        check("one_done_once", 32'(done1), 0);
        check("one_idle_busy", 32'(busy1), 0);
        step(1);
        check("one_start_ignored_busy", 32'(busy1), 0);
        check("one_start_ignored_valid", 32'(hv1), 0);
        check("one_err", 32'(err1), 0);
        check("one_inflight_end", 32'(inf1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
